// File: rtl/mlp_result_drain_if.sv
// Result stream from the drain unit: one LANES-wide beat per valid/ready
// handshake, with a last flag on the final beat of the matrix.
interface mlp_result_drain_if #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 16
) ();
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [LANES*DATA_W-1:0] out_payload_o;
   logic                    out_last_o;

   modport master (
      output out_valid_o,
      output out_payload_o,
      output out_last_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_payload_o,
      input  out_last_o,
      output out_ready_i
   );
endinterface

// File: rtl/mlp_result_drain.sv
// Captures the DIM x DIM accumulator matrix row by row, narrows it to DATA_W and
// streams it out LANES elements per beat. Define MLP_DRAIN_SAT_EN for signed clamping.
module mlp_result_drain #(
   parameter int unsigned DIM    = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned LANES  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en_i,
   input  logic [$clog2(DIM)-1:0]   wr_row_i,
   input  logic [DIM*ACC_W-1:0]     wr_data_i,
   input  logic                     start_i,
   mlp_result_drain_if.master       out_if,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     sat_o
);

   localparam int unsigned RW    = $clog2(DIM);
   localparam int unsigned BEATS = DIM * DIM / LANES;
   localparam int unsigned BPR   = DIM / LANES;
   localparam int unsigned BW    = $clog2(BEATS);

   typedef enum logic {IDLE, DRAIN} state_e;

   state_e                  state_q;
   logic [BW-1:0]           cnt_q;
   logic                    valid_q;
   logic                    last_q;
   logic                    done_q;
   logic                    err_q;
   logic [DATA_W-1:0]       mem_q [DIM][DIM];
   logic [DATA_W-1:0]       narrow_d [DIM];
   logic [RW-1:0]           row_sel;
   logic [RW-1:0]           col_base;
   logic [RW-1:0]           col;
   logic [LANES*DATA_W-1:0] payload;
   logic                    accept;

`ifdef MLP_DRAIN_SAT_EN
   logic                    sat_q;
   logic                    row_sat_d;
   logic [ACC_W-1:0]        acc;

   // An element fits iff every bit above the DATA_W sign bit matches the sign.
   always_comb begin
      narrow_d  = '{default: '0};
      row_sat_d = 1'b0;
      acc       = '0;
      for (int unsigned c = 0; c < DIM; c++) begin
         acc = wr_data_i[c*ACC_W +: ACC_W];
         if (acc[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){acc[ACC_W-1]}}) begin
            narrow_d[c] = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
            row_sat_d   = 1'b1;
         end else begin
            narrow_d[c] = acc[DATA_W-1:0];
         end
      end
   end

   assign sat_o = sat_q;
`else
   logic unused_acc_bits;

   always_comb begin
      narrow_d = '{default: '0};
      for (int unsigned c = 0; c < DIM; c++) begin
         narrow_d[c] = wr_data_i[c*ACC_W +: DATA_W];
      end
   end

   assign unused_acc_bits = ^wr_data_i;
   assign sat_o           = 1'b0;
`endif

   // Lowest column of the beat goes to the most-significant lane.
   always_comb begin
      row_sel  = RW'(cnt_q / BPR);
      col_base = RW'((cnt_q % BPR) * LANES);
      payload  = '0;
      col      = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         col = col_base + RW'(j);
         payload[(LANES-1-j)*DATA_W +: DATA_W] = mem_q[row_sel][col];
      end
   end

   assign accept = valid_q && out_if.out_ready_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MLP_DRAIN_SAT_EN
         sat_q   <= 1'b0;
`endif
         for (int unsigned r = 0; r < DIM; r++) begin
            for (int unsigned c = 0; c < DIM; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_en_i) begin
                  for (int unsigned c = 0; c < DIM; c++) begin
                     mem_q[wr_row_i][c] <= narrow_d[c];
                  end
`ifdef MLP_DRAIN_SAT_EN
                  if (row_sat_d) sat_q <= 1'b1;
`endif
               end
               if (start_i) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
               end
            end
            DRAIN: begin
               if (wr_en_i || start_i) err_q <= 1'b1;
               if (accept) begin
                  if (last_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     cnt_q   <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     last_q <= (cnt_q == BW'(BEATS - 2));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_if.out_valid_o   = valid_q;
   assign out_if.out_last_o    = last_q;
   assign out_if.out_payload_o = valid_q ? payload : '0;
   assign busy_o               = (state_q == DRAIN);
   assign done_o               = done_q;
   assign err_o                = err_q;

endmodule

// File: tb/tb_mlp_result_drain.sv
// Directed bench for mlp_result_drain: default 16x16/2-lane instance plus an 8x8/4-lane one.
module tb_mlp_result_drain;

`ifdef MLP_DRAIN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         wr_en, start;
  logic [3:0]   wr_row;
  logic [511:0] wr_data;
  logic         busy, done, err, sat;

  logic         wr_en8, start8;
  logic [2:0]   wr_row8;
  logic [255:0] wr_data8;
  logic         busy8, done8, err8, sat8;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_mem [16][16];

  mlp_result_drain_if #(.LANES(2), .DATA_W(16)) ob ();
  mlp_result_drain_if #(.LANES(4), .DATA_W(16)) ob8 ();

  mlp_result_drain #(.DIM(16), .DATA_W(16), .ACC_W(32), .LANES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_row_i(wr_row),
    .wr_data_i(wr_data), .start_i(start), .out_if(ob),
    .busy_o(busy), .done_o(done), .err_o(err), .sat_o(sat)
  );

  mlp_result_drain #(.DIM(8), .DATA_W(16), .ACC_W(32), .LANES(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en8), .wr_row_i(wr_row8),
    .wr_data_i(wr_data8), .start_i(start8), .out_if(ob8),
    .busy_o(busy8), .done_o(done8), .err_o(err8), .sat_o(sat8)
  );

  task automatic write_matrix16();
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      wr_en  = 1'b1;
      wr_row = 4'(r);
      for (int c = 0; c < 16; c++) begin
        wr_data[c*32 +: 32] = 32'(r*16 + c);
        exp_mem[r][c]       = 16'(r*16 + c);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues start at the current negedge, then accepts beats; mode 1 toggles ready 0/1.
  task automatic drain16(input int mode, input int inject_at, input int rst_at);
    int k, cyc, t_first, t_last, r, c0;
    bit seen, stalled;
    logic [31:0] held, exp_pl;
    k = 0; cyc = 0; t_first = 0; t_last = 0; seen = 0; stalled = 0; held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (ob.out_valid_o !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: valid=%b busy=%b done=%b, want 1 1 0",
               ob.out_valid_o, busy, done);
    end
    while (k < 128 && cyc < 1000) begin
      if (stalled) begin
        checks++;
        if (ob.out_payload_o !== held || ob.out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: payload=%h valid=%b, want %h 1",
                   ob.out_payload_o, ob.out_valid_o, held);
        end
        stalled = 0;
      end
      if (ob.out_valid_o === 1'b1) begin
        if (!seen) begin seen = 1; t_first = cyc; end
        if (k == rst_at) begin
          rst_n = 1'b0;
          ob.out_ready_i = 1'b0;
          @(negedge clk);
          checks++;
          if (ob.out_valid_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
              ob.out_last_o !== 1'b0 || ob.out_payload_o !== 32'h0 ||
              err !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: valid=%b busy=%b done=%b last=%b payload=%h err=%b sat=%b, want all 0",
                     ob.out_valid_o, busy, done, ob.out_last_o, ob.out_payload_o, err, sat);
          end
          rst_n = 1'b1;
          for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) exp_mem[i][j] = 16'h0;
          return;
        end
        ob.out_ready_i = (mode == 0) ? 1'b1 : (((cyc - t_first) % 2) == 1);
        if (k == inject_at) begin
          wr_en = 1'b1; wr_row = 4'd5; wr_data = '1; start = 1'b1;
        end
        if (ob.out_ready_i) begin
          r  = (k*2) / 16;
          c0 = (k*2) % 16;
          exp_pl = {exp_mem[r][c0], exp_mem[r][c0+1]};
          checks++;
          if (ob.out_payload_o !== exp_pl) begin
            errors++;
            $display("FAIL beat_payload k=%0d: got %h, want %h", k, ob.out_payload_o, exp_pl);
          end
          checks++;
          if (ob.out_last_o !== (k == 127)) begin
            errors++;
            $display("FAIL beat_last k=%0d: got %b, want %b", k, ob.out_last_o, (k == 127));
          end
          t_last = cyc;
          k++;
        end else begin
          held    = ob.out_payload_o;
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
      wr_en = 1'b0;
      start = 1'b0;
    end
    ob.out_ready_i = 1'b0;
    checks++;
    if (k != 128) begin
      errors++;
      $display("FAIL drain_count: got %0d beats, want 128", k);
    end
    checks++;
    if (t_last - t_first != ((mode == 0) ? 127 : 255)) begin
      errors++;
      $display("FAIL drain_span: got %0d cycles, want %0d", t_last - t_first, (mode == 0) ? 127 : 255);
    end
    checks++;
    if (busy !== 1'b0 || ob.out_valid_o !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: busy=%b valid=%b done=%b, want 0 0 1", busy, ob.out_valid_o, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ob.out_valid_o !== 1'b0 || ob.out_last_o !== 1'b0 || ob.out_payload_o !== 32'h0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b last=%b payload=%h busy=%b done=%b err=%b sat=%b, want all 0",
               ob.out_valid_o, ob.out_last_o, ob.out_payload_o, busy, done, err, sat);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    write_matrix16();
    drain16(0, -1, -1);
  endtask

  task automatic test_back_to_back();
    drain16(1, -1, -1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b, want 0", err);
    end
  endtask

  task automatic test_saturation();
    wr_en  = 1'b1;
    wr_row = 4'd0;
    for (int c = 0; c < 16; c++) wr_data[c*32 +: 32] = 32'(c);
    wr_data[31:0]  = 32'h0001_2345;
    wr_data[63:32] = 32'hFFFF_8000;
    exp_mem[0][0] = SAT ? 16'h7FFF : 16'h2345;
    exp_mem[0][1] = 16'h8000;
    drain16(0, -1, -1);
    checks++;
    if (sat !== SAT) begin
      errors++;
      $display("FAIL sat_flag: got %b, want %b", sat, SAT);
    end
  endtask

  task automatic test_protocol_error();
    drain16(0, 10, -1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, want 1", err);
    end
  endtask

  task automatic test_reset_mid_drain();
    drain16(0, -1, 50);
    drain16(0, -1, -1);
  endtask

  task automatic test_dim8();
    int k, cyc, r, c0;
    logic [63:0] exp8;
    for (int rr = 0; rr < 8; rr++) begin
      @(negedge clk);
      wr_en8  = 1'b1;
      wr_row8 = 3'(rr);
      for (int c = 0; c < 8; c++) wr_data8[c*32 +: 32] = 32'(rr*16 + c);
    end
    @(negedge clk);
    wr_en8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ob8.out_ready_i = 1'b1;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 100) begin
      if (ob8.out_valid_o === 1'b1) begin
        r  = (k*4) / 8;
        c0 = (k*4) % 8;
        for (int j = 0; j < 4; j++) exp8[(3-j)*16 +: 16] = 16'(r*16 + c0 + j);
        checks++;
        if (ob8.out_payload_o !== exp8) begin
          errors++;
          $display("FAIL dim8_payload k=%0d: got %h, want %h", k, ob8.out_payload_o, exp8);
        end
        checks++;
        if (ob8.out_last_o !== (k == 15)) begin
          errors++;
          $display("FAIL dim8_last k=%0d: got %b, want %b", k, ob8.out_last_o, (k == 15));
        end
        if (k == 1) begin
          checks++;
          if (ob8.out_payload_o !== 64'h0004_0005_0006_0007) begin
            errors++;
            $display("FAIL dim8_beat1: got %h, want 0004000500060007", ob8.out_payload_o);
          end
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    ob8.out_ready_i = 1'b0;
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL dim8_count: got %0d beats, want 16", k);
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL dim8_done: done=%b busy=%b, want 1 0", done8, busy8);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; start = 1'b0; wr_row = '0; wr_data = '0;
    wr_en8 = 1'b0; start8 = 1'b0; wr_row8 = '0; wr_data8 = '0;
    ob.out_ready_i = 1'b0;
    ob8.out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) exp_mem[i][j] = 16'h0;
    test_reset();
    test_full_rate();
    test_back_to_back();
    test_saturation();
    test_protocol_error();
    test_reset_mid_drain();
    test_dim8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_result_drain.md
# mlp_result_drain

Parametrised result-drain unit for the MLP accelerator. Captures the final DIM×DIM accumulator matrix from the PE array one row per cycle, narrows each ACC_W accumulator to DATA_W, and streams the matrix out LANES elements per beat over a valid/ready interface with a last flag. It replaces the fixed 16×16, two-per-word, no-backpressure readout path and sits between the PE array and the top-level result port.

## Interface
- DIM, 16, matrix rows and columns; power of two, ≥2
- DATA_W, 16, output element width
- ACC_W, 32, accumulator element width; ACC_W ≥ DATA_W
- LANES, 2, elements per output beat; power of two, divides DIM
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- wr_en_i  in  1  row write strobe
- wr_row_i  in  $clog2(DIM)  row index to write
- wr_data_i  in  DIM*ACC_W  row data; column c at bits [c*ACC_W +: ACC_W]
- start_i  in  1  begin draining the stored matrix
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  downstream ready
- out_payload_o  out  LANES*DATA_W  beat data
- out_last_o  out  1  final beat of the matrix
- busy_o  out  1  high in DRAIN
- done_o  out  1  one-cycle pulse after last beat accepted
- err_o  out  1  sticky protocol error
- sat_o  out  1  sticky saturation flag

## Operation
- Storage: DIM×DIM×DATA_W flops, zeroed by reset.
- States: IDLE, DRAIN.
- IDLE: wr_en_i writes all DIM narrowed elements of row wr_row_i at the clock edge. start_i → DRAIN; beat counter cleared to 0.
- DRAIN: beat k covers row r = (k*LANES)/DIM, columns c0 = (k*LANES) mod DIM … c0+LANES−1. Element at column c0+j is placed at out_payload_o lane (LANES−1−j), i.e. lowest column index in the most-significant lane.
- Beat accepted when out_valid_o && out_ready_i; counter increments. Total beats = DIM*DIM/LANES (128 at defaults).
- out_last_o = out_valid_o && (k == beats−1). On its acceptance → IDLE, done_o pulses next cycle.
- wr_en_i or start_i while in DRAIN: ignored (storage and counter unchanged), err_o set.
- start_i and wr_en_i together in IDLE: the write lands at that edge; drain reads the updated row.
- err_o and sat_o cleared only by reset.
- Narrowing: see Configuration; sat_o updates only on accepted writes.

## Timing
- Reset values: out_valid_o 0, out_last_o 0, out_payload_o 0, busy_o 0, done_o 0, err_o 0, sat_o 0; state IDLE, counter 0.
- Write latency: row visible to drain from the cycle after the wr_en_i edge.
- start_i sampled at edge N → out_valid_o and busy_o high in cycle N+1 with beat 0.
- Payload combinationally selected from storage by registered counter; stable while out_valid_o && !out_ready_i.
- out_valid_o never drops until its beat is accepted; no combinational path from out_ready_i to out_valid_o.
- Full-rate drain with out_ready_i held high: beats−1 cycles from first to last beat; busy_o low and done_o high in the cycle after last acceptance.
- Back-to-back start_i permitted in the done_o cycle.
- Reset asserted mid-drain: next cycle all outputs at reset values, storage zeroed, no done_o.

## Configuration
- MLP_DRAIN_SAT_EN defined: each ACC_W element clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1] (signed); any clamped element in an accepted row write sets sat_o.
- Not defined: element = low DATA_W bits of the accumulator (two's-complement wrap); sat_o tied 0.

## Test plan
- Defaults, rows written with element (r,c) = r*16+c, start, ready always 1 → 128 beats, beat 0 = 0x0000_0001, beat 127 = 0x00FE_00FF with out_last_o, done_o one cycle later.
- Same data, out_ready_i toggling 1/0 each cycle → identical beat sequence, payload stable during stalls, 255 cycles first-to-last beat.
- Element 0x0001_2345 at (0,0): with MLP_DRAIN_SAT_EN beat 0 high lane 0x7FFF, sat_o=1; without, 0x2345, sat_o=0; 0xFFFF_8000 → 0x8000 both builds.
- wr_en_i and start_i pulsed during beat 10 → err_o=1, storage and sequence unchanged, still 128 beats.
- DIM=8, LANES=4 → 16 beats, beat 1 = elements (0,4)…(0,7), last on beat 15.
- rst_n low at beat 50 → next cycle out_valid_o=0, busy_o=0; new start outputs all-zero beats.
